// File: rtl/discrete_resistor_mixer.sv
// Passive resistor summing network with power-of-two makeup gain.
// Snapshots four signed sources per strobe and mixes them with one multiply per clock.
module discrete_resistor_mixer #(
    parameter int unsigned R0         = 10000,
    parameter int unsigned R1         = 10000,
    parameter int unsigned R2         = 10000,
    parameter int unsigned R3         = 10000,
    parameter int unsigned R_LOAD     = 0,
    parameter int unsigned GAIN_SHIFT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               audio_clk_en,
    input  logic signed [15:0] in0,
    input  logic signed [15:0] in1,
    input  logic signed [15:0] in2,
    input  logic signed [15:0] in3,
    output logic signed [15:0] out,
    output logic               out_valid,
    output logic               busy
);

    localparam int unsigned DW    = 16;
    localparam int unsigned WW    = 17;
    localparam int unsigned PW    = DW + WW + 1;
    localparam int unsigned AW    = 36;
    localparam int unsigned SHIFT = 16 - GAIN_SHIFT;

    function automatic longint unsigned conductance(input longint unsigned r);
        if (r == 0) conductance = 0;
        else        conductance = (64'd1 << 30) / r;
    endfunction

    // Zero total conductance means nothing is connected; all weights collapse to 0.
    function automatic logic [WW-1:0] weight(input longint unsigned g, input longint unsigned gsum);
        if (gsum == 0) weight = '0;
        else           weight = WW'((g << 16) / gsum);
    endfunction

    localparam longint unsigned G0   = conductance(64'(R0));
    localparam longint unsigned G1   = conductance(64'(R1));
    localparam longint unsigned G2   = conductance(64'(R2));
    localparam longint unsigned G3   = conductance(64'(R3));
    localparam longint unsigned GL   = conductance(64'(R_LOAD));
    localparam longint unsigned GSUM = G0 + G1 + G2 + G3 + GL;

    localparam logic [3:0][WW-1:0] W = {weight(G3, GSUM), weight(G2, GSUM),
                                        weight(G1, GSUM), weight(G0, GSUM)};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [3:0][DW-1:0]     snap;
    logic [1:0]             idx;
    logic signed [AW-1:0]   acc;
    logic signed [PW-1:0]   sample_c;
    logic signed [PW-1:0]   coef_c;
    logic signed [PW-1:0]   prod_c;
    logic signed [AW-1:0]   shifted_c;
    logic signed [DW-1:0]   sat_c;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (audio_clk_en) state_next = MAC;
            MAC:     if (idx == 2'd3)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Signed sample times unsigned weight, both widened to the product width.
    always_comb begin
        sample_c = PW'($signed(snap[idx]));
        coef_c   = PW'($signed({1'b0, W[idx]}));
        prod_c   = sample_c * coef_c;
    end

    always_comb begin
        shifted_c = acc >>> SHIFT;
        if (shifted_c > AW'(32767))
            sat_c = 16'sh7FFF;
        else if (shifted_c < -AW'(32768))
            sat_c = -16'sh8000;
        else
            sat_c = shifted_c[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            snap      <= '0;
            idx       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (audio_clk_en) begin
                        snap <= {in3, in2, in1, in0};
                        acc  <= '0;
                        idx  <= '0;
                        busy <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc + AW'(prod_c);
                    idx <= idx + 2'd1;
                end
                DONE: begin
                    out       <= sat_c;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_discrete_resistor_mixer.sv
// Bench for discrete_resistor_mixer: four parameterisations share one stimulus
// stream and are checked against an arithmetic model of the resistor network.
module tb_discrete_resistor_mixer;

    localparam int NI = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               audio_clk_en;
    logic signed [15:0] in0, in1, in2, in3;
    logic signed [15:0] outs   [NI];
    logic               valids [NI];
    logic               busys  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance resistor networks: default, channel 1 open, gain x4, load resistor.
    int unsigned cfg_r  [NI][4] = '{'{10000, 10000, 10000, 10000},
                                   '{10000, 0,     10000, 10000},
                                   '{10000, 10000, 10000, 10000},
                                   '{10000, 10000, 10000, 10000}};
    int unsigned cfg_rl [NI]    = '{0, 0, 0, 10000};
    int unsigned cfg_g  [NI]    = '{0, 0, 2, 0};

    always #5 clk = ~clk;

    discrete_resistor_mixer u_def (.clk(clk), .reset(reset), .audio_clk_en(audio_clk_en),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out(outs[0]), .out_valid(valids[0]), .busy(busys[0]));

    discrete_resistor_mixer #(.R1(0)) u_open (.clk(clk), .reset(reset), .audio_clk_en(audio_clk_en),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out(outs[1]), .out_valid(valids[1]), .busy(busys[1]));

    discrete_resistor_mixer #(.GAIN_SHIFT(2)) u_gain (.clk(clk), .reset(reset), .audio_clk_en(audio_clk_en),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out(outs[2]), .out_valid(valids[2]), .busy(busys[2]));

    discrete_resistor_mixer #(.R_LOAD(10000)) u_load (.clk(clk), .reset(reset), .audio_clk_en(audio_clk_en),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out(outs[3]), .out_valid(valids[3]), .busy(busys[3]));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Ideal network: conductance-weighted average, makeup gain, clip to 16 bits.
    function automatic longint model(input int k, input longint x0, input longint x1,
                                     input longint x2, input longint x3);
        longint g [4];
        longint gl, gs, acc, res;
        longint x [4];
        x  = '{x0, x1, x2, x3};
        gs = 0;
        for (int j = 0; j < 4; j++) begin
            g[j] = (cfg_r[k][j] == 0) ? 0 : (longint'(1) << 30) / longint'(cfg_r[k][j]);
            gs  += g[j];
        end
        gl  = (cfg_rl[k] == 0) ? 0 : (longint'(1) << 30) / longint'(cfg_rl[k]);
        gs += gl;
        acc = 0;
        if (gs != 0)
            for (int j = 0; j < 4; j++) acc += x[j] * ((g[j] * 65536) / gs);
        res = floor_div(acc, longint'(1) << (16 - cfg_g[k]));
        if (res > 32767)  res = 32767;
        if (res < -32768) res = -32768;
        return res;
    endfunction

    // One strobe, bounded wait for the result, then compare every instance.
    task automatic mix(input logic signed [15:0] a0, input logic signed [15:0] a1,
                       input logic signed [15:0] a2, input logic signed [15:0] a3,
                       input string tag);
        int lat;
        int busy_n;
        @(negedge clk);
        in0 = a0; in1 = a1; in2 = a2; in3 = a3;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        in0 = 16'($urandom); in1 = 16'($urandom); in2 = 16'($urandom); in3 = 16'($urandom);
        lat    = 0;
        busy_n = 0;
        while (!valids[0] && lat < 20) begin
            if (busys[0]) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 5);
        check({tag, " busy_cycles"}, busy_n, 5);
        check({tag, " busy_at_valid"}, longint'(busys[0]), 0);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s valid[%0d]", tag, k), longint'(valids[k]), 1);
            check($sformatf("%s out[%0d]", tag, k), longint'(outs[k]),
                  model(k, longint'(a0), longint'(a1), longint'(a2), longint'(a3)));
        end
        @(negedge clk);
        check({tag, " valid_pulse"}, longint'(valids[0]), 0);
    endtask

    initial begin
        int vcount;
        longint vout;
        logic signed [15:0] r [4];

        reset = 1'b1; audio_clk_en = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset out[%0d]", k), longint'(outs[k]), 0);
            check($sformatf("reset valid[%0d]", k), longint'(valids[k]), 0);
            check($sformatf("reset busy[%0d]", k), longint'(busys[k]), 0);
        end
        reset = 1'b0;
        @(negedge clk);

        mix(16'sd8000, 16'sd8000, 16'sd8000, 16'sd8000, "equal");
        check("equal literal", longint'(outs[0]), 8000);
        mix(16'sd30000, 16'sd12345, 16'sd30000, 16'sd30000, "open_ch");
        check("open_ch literal", longint'(outs[1]), 29999);
        mix(16'sd16000, 16'sd16000, 16'sd16000, 16'sd16000, "sat_pos");
        check("sat_pos literal", longint'(outs[2]), 32767);
        mix(-16'sd16000, -16'sd16000, -16'sd16000, -16'sd16000, "sat_neg");
        check("sat_neg literal", longint'(outs[2]), -32768);
        mix(16'sd10000, 16'sd10000, 16'sd10000, 16'sd10000, "load");
        check("load literal", longint'(outs[3]), 7999);
        mix(-16'sd1, -16'sd1, -16'sd1, -16'sd1, "floor");
        check("floor literal", longint'(outs[3]), -1);

        // Second strobe two cycles into a mix must be dropped.
        @(negedge clk);
        in0 = 16'sd8000; in1 = 16'sd8000; in2 = 16'sd8000; in3 = 16'sd8000;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        @(negedge clk);
        in0 = -16'sd8000; in1 = -16'sd8000; in2 = -16'sd8000; in3 = -16'sd8000;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        vcount = 0; vout = 0;
        for (int c = 0; c < 10; c++) begin
            if (valids[0]) begin vcount++; vout = longint'(outs[0]); end
            @(negedge clk);
        end
        check("busy_strobe valid_count", vcount, 1);
        check("busy_strobe out", vout, 8000);
        mix(-16'sd8000, -16'sd8000, -16'sd8000, -16'sd8000, "after_busy");
        check("after_busy literal", longint'(outs[0]), -8000);

        // Reset three edges into a mix, with a coincident strobe.
        @(negedge clk);
        in0 = 16'sd5000; in1 = 16'sd5000; in2 = 16'sd5000; in3 = 16'sd5000;
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; audio_clk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0; audio_clk_en = 1'b0;
        check("abort out", longint'(outs[0]), 0);
        check("abort busy", longint'(busys[0]), 0);
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            if (valids[0]) vcount++;
            @(negedge clk);
        end
        check("abort valid_count", vcount, 0);
        check("abort busy_after", longint'(busys[0]), 0);
        mix(16'sd1234, -16'sd4321, 16'sd777, -16'sd32768, "post_abort");

        // Random mixes across the full input range with random idle gaps.
        for (int t = 0; t < 30; t++) begin
            for (int j = 0; j < 4; j++) r[j] = 16'($urandom);
            mix(r[0], r[1], r[2], r[3], $sformatf("rand%0d", t));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
